// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive FIFO with occupancy, almost-full, sticky error flags, flush and BIST write-blocking
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic [DATA_BITS-1:0]                 Rx_Data,
  input  logic                                 Data_Rdy,
  input  logic                                 Read_Done,
  input  logic                                 BIST_Mode,
  input  logic                                 Flush,
  input  logic                                 Clr_Flags,
  output logic [DATA_BITS-1:0]                 Data_Out,
  output logic                                 Data_Valid,
  output logic                                 FIFO_Empty,
  output logic                                 FIFO_Full,
  output logic                                 FIFO_Almost_Full,
  output logic                                 FIFO_Overflow,
  output logic                                 FIFO_Underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      Count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] AF_C    = (PW+1)'(AF_LEVEL);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic wr, rd_acc, wr_acc, empty, full;
  assign count            = wptr_q - rptr_q;
  assign empty            = count == '0;
  assign full             = count == DEPTH_C;
  assign Count            = count;
  assign FIFO_Empty       = empty;
  assign FIFO_Full        = full;
  assign FIFO_Almost_Full = count >= AF_C;
  assign FIFO_Overflow    = ovf_q;
  assign FIFO_Underflow   = udf_q;
  assign Data_Out         = data_out_q;
  assign Data_Valid       = data_valid_q;
  // A concurrent read frees a slot, so a full FIFO still takes a write; flush suppresses both.
  always_comb begin
    wr           = Data_Rdy & ~BIST_Mode;
    rd_acc       = Read_Done & ~empty & ~Flush;
    wr_acc       = wr & (~full | Read_Done) & ~Flush;
    wptr_d       = Flush ? '0 : wptr_q + (PW+1)'(wr_acc);
    rptr_d       = Flush ? '0 : rptr_q + (PW+1)'(rd_acc);
    data_out_d   = rd_acc ? mem[rptr_q[PW-1:0]] : data_out_q;
    data_valid_d = rd_acc;
    ovf_d        = Flush ? 1'b0 : (ovf_q & ~Clr_Flags) | (wr & full & ~Read_Done);
    udf_d        = Flush ? 1'b0 : (udf_q & ~Clr_Flags) | (Read_Done & empty);
  end
  // Storage needs no reset; entries are only observable after being written.
  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wptr_q[PW-1:0]] <= Rx_Data;
  end
  // Pointer, read-data and flag registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed stimulus against a queue-based reference model with a read-data scoreboard
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [7:0] Rx_Data = '0;
  logic Data_Rdy = 0, Read_Done = 0, BIST_Mode = 0, Flush = 0, Clr_Flags = 0;
  logic [7:0] Data_Out;
  logic Data_Valid, FIFO_Empty, FIFO_Full, FIFO_Almost_Full, FIFO_Overflow, FIFO_Underflow;
  logic [4:0] Count;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic m_ovf = 0, m_udf = 0, m_dv = 0;
  logic [7:0] m_out = '0;

  uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .Clk(Clk), .Rst(Rst), .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy), .Read_Done(Read_Done),
    .BIST_Mode(BIST_Mode), .Flush(Flush), .Clr_Flags(Clr_Flags), .Data_Out(Data_Out),
    .Data_Valid(Data_Valid), .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
    .FIFO_Almost_Full(FIFO_Almost_Full), .FIFO_Overflow(FIFO_Overflow),
    .FIFO_Underflow(FIFO_Underflow), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Read-data monitor: each Data_Valid pulse must match the oldest outstanding expected word.
  always @(negedge Clk) begin
    if (!Rst && Data_Valid) begin
      if (exp_q.size() == 0) chk("dv_spurious", 1, 0);
      else chk("rd_data", int'(Data_Out), int'(exp_q.pop_front()));
    end
  end

  task automatic check_status();
    int n = q.size();
    chk("count", int'(Count), n);
    chk("empty", int'(FIFO_Empty), int'(n == 0));
    chk("full", int'(FIFO_Full), int'(n == DEPTH));
    chk("afull", int'(FIFO_Almost_Full), int'(n >= AF));
    chk("ovf", int'(FIFO_Overflow), int'(m_ovf));
    chk("udf", int'(FIFO_Underflow), int'(m_udf));
    chk("dout_hold", int'(Data_Out), int'(m_out));
    chk("dvalid", int'(Data_Valid), int'(m_dv));
  endtask

  task automatic model_reset();
    q.delete(); exp_q.delete();
    m_ovf = 0; m_udf = 0; m_dv = 0; m_out = '0;
  endtask

  task automatic step(input logic dr, input logic rd, input logic bist, input logic fl,
                      input logic clr, input logic [7:0] din);
    logic wr, emp, ful, ev_o, ev_u;
    @(negedge Clk);
    check_status();
    Data_Rdy = dr; Read_Done = rd; BIST_Mode = bist; Flush = fl; Clr_Flags = clr; Rx_Data = din;
    m_dv = 0;
    if (fl) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      wr = dr & !bist;
      emp = q.size() == 0;
      ful = q.size() == DEPTH;
      ev_o = wr & ful & !rd;
      ev_u = rd & emp;
      if (rd && !emp) begin
        m_out = q.pop_front();
        exp_q.push_back(m_out);
        m_dv = 1;
      end
      if (wr && (!ful || rd)) q.push_back(din);
      if (clr) begin m_ovf = 0; m_udf = 0; end
      m_ovf |= ev_o;
      m_udf |= ev_u;
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 8'h00); endtask
  task automatic wr1(input logic [7:0] d); step(1, 0, 0, 0, 0, d); endtask
  task automatic rd1(); step(0, 1, 0, 0, 0, 8'h00); endtask

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    check_status();
    Rst = 0;
    for (int i = 0; i < 15; i++) wr1(8'h11 + 8'(i));
    idle();
    for (int i = 0; i < 15; i++) rd1();
    idle(); idle();
    for (int i = 0; i < 16; i++) wr1(8'($urandom));
    wr1(8'hAA);
    idle();
    for (int i = 0; i < 16; i++) rd1();
    step(0, 0, 0, 0, 1, 8'h00);
    idle();
    for (int i = 0; i < 16; i++) wr1(8'($urandom));
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 0, 8'($urandom));
    for (int i = 0; i < 16; i++) rd1();
    idle();
    rd1();
    step(1, 1, 0, 0, 0, 8'h3C);
    rd1();
    step(0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) wr1(8'h60 + 8'(i));
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 16; i++) wr1(8'($urandom));
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 5; i++) wr1(8'($urandom));
    step(1, 0, 0, 1, 0, 8'h77);
    idle();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, 8'($urandom));
    for (int i = 0; i < 6; i++) wr1(8'($urandom));
    rd1();
    step(1, 1, 0, 0, 0, 8'($urandom));
    #2 Rst = 1;
    #1;
    chk("rst_count", int'(Count), 0);
    chk("rst_empty", int'(FIFO_Empty), 1);
    chk("rst_full", int'(FIFO_Full), 0);
    chk("rst_afull", int'(FIFO_Almost_Full), 0);
    chk("rst_ovf", int'(FIFO_Overflow), 0);
    chk("rst_udf", int'(FIFO_Underflow), 0);
    chk("rst_dout", int'(Data_Out), 0);
    chk("rst_dvalid", int'(Data_Valid), 0);
    model_reset();
    Data_Rdy = 0; Read_Done = 0; BIST_Mode = 0; Flush = 0; Clr_Flags = 0;
    repeat (2) @(negedge Clk);
    Rst = 0;
    idle();
    wr1(8'h42);
    rd1();
    idle(); idle();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised synchronous receive FIFO between the UART receiver and the host read interface. It is the clocked successor to the event-driven receive FIFO. It stores up to FIFO_DEPTH received words in a circular buffer and supports simultaneous read and write. It provides occupancy count, almost-full, sticky overflow/underflow, flush, and BIST write-blocking.

## Interface
- DATA_BITS, 8, word width.
- FIFO_DEPTH, 16, entry count; power of two, ≥ 2.
- AF_LEVEL, 12, almost-full threshold; 1 ≤ AF_LEVEL ≤ FIFO_DEPTH.
- Clk  in  1  single clock; all state on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Rx_Data  in  DATA_BITS  word from receiver.
- Data_Rdy  in  1  write strobe; each high cycle = one write request.
- Read_Done  in  1  read strobe; each high cycle = one read request.
- BIST_Mode  in  1  high: write requests ignored; reads still serviced.
- Flush  in  1  synchronous clear of contents and flags.
- Clr_Flags  in  1  synchronous clear of FIFO_Overflow/FIFO_Underflow.
- Data_Out  out  DATA_BITS  registered read data.
- Data_Valid  out  1  one-cycle pulse: Data_Out updated this cycle.
- FIFO_Empty  out  1  Count == 0.
- FIFO_Full  out  1  Count == FIFO_DEPTH.
- FIFO_Almost_Full  out  1  Count ≥ AF_LEVEL.
- FIFO_Overflow  out  1  sticky: write lost.
- FIFO_Underflow  out  1  sticky: read of empty FIFO.
- Count  out  $clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
- Storage: FIFO_DEPTH×DATA_BITS array. WPtr/RPtr are $clog2(FIFO_DEPTH)+1 bits; index = low bits, wrap naturally. Count = WPtr − RPtr (modulo).
- Effective write wr = Data_Rdy & !BIST_Mode. Effective read rd = Read_Done.
- Write accepted if wr & (!full | rd): mem[WPtr] ← Rx_Data, WPtr+1.
- Read accepted if rd & !empty: Data_Out ← mem[RPtr], RPtr+1, Data_Valid=1 next cycle.
- Full + rd + wr: both accepted, Count unchanged; read returns the oldest word, never the word being written.
- Empty + rd + wr: write accepted, read rejected, FIFO_Underflow set. Data_Out unchanged. No write-through.
- wr while full with no rd: data dropped, contents unchanged, FIFO_Overflow set.
- BIST_Mode high: Data_Rdy has no effect, including on Overflow.
- Flush: pointers → 0, Overflow/Underflow → 0. Data_Out is held. Flush overrides any same-cycle rd/wr; both are ignored.
- Clr_Flags: clears both sticky flags. A same-cycle new overflow/underflow event wins, so the flag is set.
- Stored array contents need not be reset. They are unobservable while empty.
- Status outputs (Empty, Full, Almost_Full, Count) are combinational from the pointer registers. They are valid the cycle after the causing edge.

## Timing
- Reset values: Data_Out=0, Data_Valid=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Almost_Full=0 (AF_LEVEL ≥ 1), FIFO_Overflow=0, FIFO_Underflow=0, Count=0, WPtr=RPtr=0.
- Rst mid-operation: state clears immediately and asynchronously. In-flight strobes are lost. The first operation is on the first rising edge after Rst deasserts.
- Write latency: word written at edge N → Count/Empty reflect it after edge N. The word is readable by Read_Done sampled at edge N+1.
- Read latency: Read_Done high at edge N → Data_Out/Data_Valid valid after edge N, for one cycle of Data_Valid. Data_Out holds until the next accepted read.
- Throughput: one write and one read per cycle, sustained.
- Wrap: pointers wrap from FIFO_DEPTH−1 to 0 without bubble. Full/empty are distinguished by pointer MSB.

## Test plan
- Reset, then write 0x11..0x1F (15 words, DEPTH=16) → Count=15, Almost_Full=1 from the 12th write, Full=0. Read 15 → Data_Out sequence 0x11..0x1F, Empty=1.
- Fill to 16, write 0xAA → Overflow=1, Count=16. Read all → 0xAA absent. Clr_Flags → Overflow=0.
- Full, simultaneous Read_Done+Data_Rdy(0x55) for 40 cycles → Count stays 16, Overflow=0, outputs in exact write order across ≥2 pointer wraps.
- Empty, Read_Done alone → Underflow=1, Data_Valid=0. Empty + Read_Done + Data_Rdy(0x3C) → Count=1, next read returns 0x3C.
- BIST_Mode=1 with Data_Rdy pulses → Count unchanged, Overflow=0. Reads still drain prior contents.
- Write 5 words, Flush with concurrent Data_Rdy → Count=0, Empty=1. Assert Rst mid-burst → all outputs at reset values immediately, before the next edge.
